mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-to-memory arbiter: FSM state encoding,
// grant identifiers and default bus widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERV_I  = 2'd1,
        SERV_D  = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requesters.
// Default build: fixed priority, D over I.
// With MEM_ARB_RR_EN defined: a tie goes to whoever did not win last time.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_pend,
    input  logic d_pend,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    // Pick a winner whenever at least one side is pending
    always_comb begin
        gnt_valid = i_pend | d_pend;
        gnt_id    = GNT_I;
`ifdef MEM_ARB_RR_EN
        if (i_pend && d_pend) begin
            gnt_id = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (d_pend) begin
            gnt_id = GNT_D;
        end
`else
        if (d_pend) begin
            gnt_id = GNT_D;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single off-chip memory port between the I-cache and D-cache.
// One block transfer at a time; every output is registered.
// Optional macro MEM_ARB_RR_EN: alternate grants on a tie instead of
// always favouring the D-cache.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    state_t              state_q, state_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                busy_q, busy_d;

    logic i_pend, d_pend;
    logic gnt_valid, gnt_id;
    logic last_grant;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    mem_arb_pick u_pick (
        .i_pend     (i_pend),
        .d_pend     (d_pend),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // Record the winner of every grant so the next tie goes the other way
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && gnt_valid) begin
            last_grant_d = gnt_id;
        end
    end

    // Grant history register, starts as if I had won last
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = GNT_I;
`endif

    // Next-state and next-output logic for the grant/serve/release cycle
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    if (gnt_id == GNT_D) begin
                        state_d    = SERV_D;
                        mem_addr_d = d_addr;
                        if (d_write) begin
                            mem_write_d = 1'b1;
                            mem_read_d  = 1'b0;
                            mem_wdata_d = d_wdata;
                        end else begin
                            mem_write_d = 1'b0;
                            mem_read_d  = 1'b1;
                            mem_wdata_d = '0;
                        end
                    end else begin
                        state_d     = SERV_I;
                        mem_addr_d  = i_addr;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            SERV_I: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    i_rdata_d  = mem_rdata;
                    i_ready_d  = 1'b1;
                    state_d    = RELEASE;
                end
            end
            SERV_D: begin
                if (mem_ready) begin
                    if (mem_read_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    d_ready_d   = 1'b1;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            busy_q      <= busy_d;
        end
    end

    // A D-side read and writeback at the same time is a cache bug
    a_no_dual_d_req: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory, a bus monitor
// and a transaction-level reference model of grant order and returned data.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [27:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_ready;
    logic         d_read;
    logic         d_write;
    logic [27:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Backing-store contents for addresses never written
    function automatic logic [127:0] init_block(input logic [27:0] a);
        return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory device contents and the reference model's own copy
    logic [127:0] mem_store [logic [27:0]];
    logic [127:0] ref_mem   [logic [27:0]];

    function automatic logic [127:0] ref_rd(input logic [27:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_block(a);
    endfunction

    // Reference model state: who won last and what each cache should hold
    bit           model_last_d = 1'b0;
    logic [127:0] exp_i_rdata  = '0;
    logic [127:0] exp_d_rdata  = '0;

    function automatic bit model_picks_d(input bit ip, input bit dp);
`ifdef MEM_ARB_RR_EN
        if (ip && dp) return !model_last_d;
`endif
        return dp;
    endfunction

    // Slow memory: answers a held strobe after mem_lat cycles with one ready pulse
    int mem_lat = 3;
    int mcnt = 0;
    bit spur_req = 1'b0;

    always @(negedge clk) begin : memory_model
        if (rst) begin
            mem_ready = 1'b0;
            mcnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mcnt = 0;
        end else if (spur_req) begin
            mem_ready = 1'b1;
            mem_rdata = rand128();
            spur_req = 1'b0;
        end else if (mem_read || mem_write) begin
            mcnt = mcnt + 1;
            if (mcnt >= mem_lat) begin
                mem_ready = 1'b1;
                if (mem_write) begin
                    mem_store[mem_addr] = mem_wdata;
                    mem_rdata = rand128();
                end else begin
                    mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_block(mem_addr);
                end
            end
        end
    end

    // Bus monitor: logs each memory strobe episode and each ready pulse
    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        int           start;
        int           len;
        bit           stable;
    } xact_t;

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } rdy_t;

    xact_t obs_q[$];
    rdy_t  i_rdy_q[$];
    rdy_t  d_rdy_q[$];
    bit    strobe_prev = 1'b0;

    always @(negedge clk) begin : monitor
        xact_t x;
        rdy_t  r;
        int    k;
        cyc = cyc + 1;
        if ((mem_read || mem_write) && !strobe_prev) begin
            x.wr = mem_write;
            x.addr = mem_addr;
            x.wdata = mem_wdata;
            x.start = cyc;
            x.len = 1;
            x.stable = (mem_read !== mem_write);
            obs_q.push_back(x);
        end else if ((mem_read || mem_write) && obs_q.size() > 0) begin
            k = obs_q.size() - 1;
            obs_q[k].len = obs_q[k].len + 1;
            if (obs_q[k].wr !== mem_write || obs_q[k].addr !== mem_addr ||
                obs_q[k].wdata !== mem_wdata || mem_read === mem_write)
                obs_q[k].stable = 1'b0;
        end
        if (i_ready === 1'b1) begin
            r.cyc = cyc;
            r.data = i_rdata;
            i_rdy_q.push_back(r);
        end
        if (d_ready === 1'b1) begin
            r.cyc = cyc;
            r.data = d_rdata;
            d_rdy_q.push_back(r);
        end
        strobe_prev = mem_read || mem_write;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_q.delete();
        i_rdy_q.delete();
        d_rdy_q.delete();
    endtask

    // One request round from either or both caches, each cache dropping its
    // request on its own ready pulse, checked against the transaction model
    task automatic do_transaction(input bit ien, input bit den, input bit dwr,
                                  input logic [27:0] ia, input logic [27:0] da,
                                  input logic [127:0] wd, input int lat, input string tag);
        bit          order [2];
        int          n_exp;
        int          t0;
        int          guard;
        int          r_cyc;
        int          prev_rdy;
        bit          exp_wr;
        logic [27:0] exp_addr;
        int          exp_start;

        clear_logs();
        n_exp = 0;
        if (ien || den) begin
            order[0] = model_picks_d(ien, den);
            model_last_d = order[0];
            n_exp = 1;
            if (ien && den) begin
                order[1] = !order[0];
                model_last_d = order[1];
                n_exp = 2;
            end
        end
        for (int n = 0; n < n_exp; n++) begin
            if (order[n]) begin
                if (dwr) ref_mem[da] = wd;
                else exp_d_rdata = ref_rd(da);
            end else begin
                exp_i_rdata = ref_rd(ia);
            end
        end

        mem_lat = lat;
        t0 = cyc;
        i_read = ien;
        i_addr = ia;
        d_read = den && !dwr;
        d_write = den && dwr;
        d_addr = da;
        d_wdata = wd;

        guard = 0;
        while ((i_read || d_read || d_write) && guard < 200) begin
            tick();
            guard++;
            if (i_ready === 1'b1) i_read = 1'b0;
            if (d_ready === 1'b1) begin
                d_read = 1'b0;
                d_write = 1'b0;
            end
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("[TB] FAIL %s timeout: got no ready within %0d cycles, required completion", tag, guard);
            i_read = 1'b0;
            d_read = 1'b0;
            d_write = 1'b0;
        end
        repeat (3) tick();

        checks++;
        if (obs_q.size() != n_exp) begin
            errors++;
            $display("[TB] FAIL %s xact_count: got %0d expected %0d", tag, obs_q.size(), n_exp);
        end

        prev_rdy = -1;
        for (int n = 0; n < n_exp && n < obs_q.size(); n++) begin
            exp_wr = order[n] ? dwr : 1'b0;
            exp_addr = order[n] ? da : ia;
            if (order[n]) r_cyc = (d_rdy_q.size() > 0) ? d_rdy_q[0].cyc : -1;
            else r_cyc = (i_rdy_q.size() > 0) ? i_rdy_q[0].cyc : -1;
            exp_start = (n == 0) ? t0 + 1 : prev_rdy + 2;

            checks++;
            if (obs_q[n].wr !== exp_wr) begin
                errors++;
                $display("[TB] FAIL %s x%0d kind: got write=%0b expected write=%0b", tag, n, obs_q[n].wr, exp_wr);
            end
            checks++;
            if (obs_q[n].addr !== exp_addr) begin
                errors++;
                $display("[TB] FAIL %s x%0d mem_addr: got %h expected %h", tag, n, obs_q[n].addr, exp_addr);
            end
            if (exp_wr) begin
                checks++;
                if (obs_q[n].wdata !== wd) begin
                    errors++;
                    $display("[TB] FAIL %s x%0d mem_wdata: got %h expected %h", tag, n, obs_q[n].wdata, wd);
                end
            end
            checks++;
            if (obs_q[n].len != lat || !obs_q[n].stable) begin
                errors++;
                $display("[TB] FAIL %s x%0d strobe: got len=%0d stable=%0b expected len=%0d stable=1", tag, n, obs_q[n].len, obs_q[n].stable, lat);
            end
            checks++;
            if (obs_q[n].start != exp_start) begin
                errors++;
                $display("[TB] FAIL %s x%0d strobe_start: got cycle %0d expected cycle %0d", tag, n, obs_q[n].start, exp_start);
            end
            checks++;
            if (r_cyc != obs_q[n].start + lat) begin
                errors++;
                $display("[TB] FAIL %s x%0d ready_cycle: got %0d expected %0d", tag, n, r_cyc, obs_q[n].start + lat);
            end
            prev_rdy = r_cyc;
        end

        checks++;
        if (i_rdy_q.size() != int'(ien) || d_rdy_q.size() != int'(den)) begin
            errors++;
            $display("[TB] FAIL %s ready_pulses: got i=%0d d=%0d expected i=%0d d=%0d", tag, i_rdy_q.size(), d_rdy_q.size(), ien, den);
        end
        if (ien && i_rdy_q.size() > 0) begin
            checks++;
            if (i_rdy_q[0].data !== exp_i_rdata) begin
                errors++;
                $display("[TB] FAIL %s i_rdata_at_ready: got %h expected %h", tag, i_rdy_q[0].data, exp_i_rdata);
            end
        end
        checks++;
        if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
            errors++;
            $display("[TB] FAIL %s rdata_hold: got i=%h d=%h expected i=%h d=%h", tag, i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
        end
        checks++;
        if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle_after: got busy=%b rd=%b wr=%b expected 0 0 0", tag, busy, mem_read, mem_write);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready, busy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL %s ctrl: got rd=%b wr=%b ir=%b dr=%b busy=%b expected all 0", tag, mem_read, mem_write, i_ready, d_ready, busy);
        end
        checks++;
        if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            errors++;
            $display("[TB] FAIL %s mem_bus: got addr=%h wdata=%h expected 0", tag, mem_addr, mem_wdata);
        end
        checks++;
        if (i_rdata !== 128'h0 || d_rdata !== 128'h0) begin
            errors++;
            $display("[TB] FAIL %s rdata: got i=%h d=%h expected 0", tag, i_rdata, d_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_read = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_i_read();
        mem_store[28'h0000010] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        ref_mem[28'h0000010]   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        do_transaction(1'b1, 1'b0, 1'b0, 28'h0000010, 28'h0, 128'h0, 5, "i_read");
    endtask

    task automatic test_d_write();
        do_transaction(1'b0, 1'b1, 1'b0, 28'h0, 28'h0000333, 128'h0, 2, "d_read_pre");
        do_transaction(1'b0, 1'b1, 1'b1, 28'h0, 28'h0000020, 128'h1, 3, "d_write");
    endtask

    task automatic test_back_to_back();
        for (int rep = 0; rep < 3; rep++) begin
            do_transaction(1'b1, 1'b1, 1'b0, 28'h0000100 + 28'(rep), 28'h0000200 + 28'(rep), 128'h0, 1 + rep, "both_read");
        end
    endtask

    task automatic test_spurious_ready();
        clear_logs();
        spur_req = 1'b1;
        repeat (4) tick();
        checks++;
        if (i_rdy_q.size() + d_rdy_q.size() != 0 || obs_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_ready activity: got i=%0d d=%0d xact=%0d busy=%b expected none", i_rdy_q.size(), d_rdy_q.size(), obs_q.size(), busy);
        end
        checks++;
        if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
            errors++;
            $display("[TB] FAIL spurious_ready rdata: got i=%h d=%h expected i=%h d=%h", i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
        end
        do_transaction(1'b1, 1'b0, 1'b0, 28'h0000444, 28'h0, 128'h0, 2, "after_spurious");
    endtask

    task automatic test_stale_request();
        int          guard;
        logic [27:0] ia;
        ia = 28'($urandom);
        clear_logs();
        mem_lat = 2;
        exp_i_rdata = ref_rd(ia);
        model_last_d = 1'b0;
        i_addr = ia;
        i_read = 1'b1;
        guard = 0;
        while (i_rdy_q.size() < 2 && guard < 100) begin
            tick();
            guard++;
        end
        i_read = 1'b0;
        repeat (3) tick();
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("[TB] FAIL stale timeout: got %0d ready pulses, required 2", i_rdy_q.size());
        end
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL stale regrant_count: got %0d expected 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[1].addr !== ia || obs_q[1].wr !== 1'b0 || obs_q[1].start != i_rdy_q[0].cyc + 2) begin
                errors++;
                $display("[TB] FAIL stale regrant: got addr=%h wr=%0b start=%0d expected addr=%h wr=0 start=%0d", obs_q[1].addr, obs_q[1].wr, obs_q[1].start, ia, i_rdy_q[0].cyc + 2);
            end
        end
        checks++;
        if (i_rdata !== exp_i_rdata) begin
            errors++;
            $display("[TB] FAIL stale i_rdata: got %h expected %h", i_rdata, exp_i_rdata);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        mem_lat = 20;
        d_addr = 28'h0000777;
        d_read = 1'b1;
        tick();
        checks++;
        if (mem_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid pre: got mem_read=%b busy=%b expected 1 1", mem_read, busy);
        end
        rst = 1'b1;
        d_read = 1'b0;
        tick();
        check_all_zero("reset_mid");
        rst = 1'b0;
        model_last_d = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        do_transaction(1'b1, 1'b0, 1'b0, 28'h0000888, 28'h0, 128'h0, 3, "after_reset");
    endtask

    task automatic test_random();
        int          sel;
        bit          dwr;
        logic [27:0] ia;
        logic [27:0] da;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(1, 3);
            dwr = 1'($urandom_range(0, 1));
            ia = 28'($urandom);
            da = ($urandom_range(0, 3) == 0) ? ia : 28'($urandom);
            do_transaction(sel[0], sel[1], dwr, ia, da, rand128(), $urandom_range(1, 6), "random");
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_back_to_back();
        test_spurious_ready();
        test_stale_request();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
